uart_wb_master: RTL and testbench
=================================

Name: uart_wb_master

Overview:
- Serial-to-Wishbone bridge: accepts framed command bytes on a UART RX line and issues single 32-bit Wishbone initiator cycles.
- Returns status or read data on a UART TX line.
- Opposite end of our Wishbone UART peripheral. Used as a host debug and load port that drives the internal Wishbone bus, e.g. to preload and read back accelerator registers.

Parameters:
- CLK_DIV, 16, clock cycles per UART bit; legal range >= 4.
- TIMEOUT, 1024, cycles to wait for wbm_ack_i before aborting. Only used with the optional feature.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- ser_rx  in  1  UART receive line, idle high. Synchronised internally through 2 flops.
- ser_tx  out  1  UART transmit line, idle high.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_sel_o  out  4  byte selects; always 4'b1111 while wbm_stb_o is high.
- wbm_we_o  out  1  write enable.
- wbm_cyc_o  out  1  cycle.
- wbm_stb_o  out  1  strobe.
- wbm_ack_i  in  1  acknowledge.
- wbm_dat_i  in  32  Wishbone read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - ser_tx=1.
  - wbm_cyc_o, wbm_stb_o, wbm_we_o = 0.
  - wbm_adr_o, wbm_dat_o, wbm_sel_o = 0.
  - busy=0.
  - State = IDLE; RX and TX engines idle.
  - Reset asserted mid-frame or mid-cycle aborts immediately and sends no response.
- UART format: 8N1, LSB first, one bit period = CLK_DIV cycles.
- RX engine:
  - A falling edge on the synchronised ser_rx while RX is idle starts a frame.
  - Start bit is resampled at CLK_DIV/2; if high, treat as a glitch and return to RX idle.
  - Data bits are sampled at each mid-bit.
  - Stop bit is sampled mid-bit. If low, it is a framing error: discard the byte and force the parser to IDLE.
  - A valid byte gives a 1-cycle rx_valid pulse.
- Command protocol (multi-byte fields are MSB first):
  - 0x57 'W' + 4 address bytes + 4 data bytes = write.
  - 0x52 'R' + 4 address bytes = read.
  - Any other byte in IDLE is ignored.
- Parser FSM:
  - IDLE -> ADDR on 'W'/'R'; latch the we flag.
  - ADDR collects 4 bytes by shifting into wbm_adr_o. Then go to WDATA if writing, else BUS.
  - WDATA collects 4 bytes by shifting into wbm_dat_o, then BUS.
  - BUS: on entry, assert cyc=stb=1, sel=1111, we=flag. Hold until wbm_ack_i is sampled high.
    - On the ack edge: deassert cyc/stb/we; if reading, capture wbm_dat_i.
    - Minimum bus cycle is 1 clock with ack; no pipelining; ack before stb is ignored.
  - RESP: transmit 0x4B 'K' after a write, or 4 read-data bytes MSB first after a read; then IDLE.
  - Bytes received in BUS or RESP are dropped.
- TX engine: start bit, 8 data bits, stop bit, each CLK_DIV cycles. The next byte is loaded the cycle after the stop bit ends, so there is no extra idle between response bytes.
- Latency: wbm_stb_o rises 1 cycle after the rx_valid of the final command byte. The TX start bit begins 1 cycle after the ack edge.
- Widths: bit counters 4 bits; divider counter $clog2(CLK_DIV)+1 bits, wrapping to 0 at CLK_DIV-1.

Optional Feature:
- Macro: UART_WB_MASTER_TIMEOUT_EN.
- Defined: a counter runs while in BUS.
  - Reaching TIMEOUT with no ack drops cyc/stb and sends 0x45 'E' as the sole response byte, for both read and write.
  - An ack on the same cycle as the timeout wins; normal response.
- Undefined: BUS waits indefinitely for ack; the counter and TIMEOUT logic are not synthesised.

Decomposition:
- Package uart_wbm_pkg:
  - Command and response byte constants: CMD_WR, CMD_RD, RSP_OK, RSP_ERR.
  - Parser state enum: IDLE, ADDR, WDATA, BUS, RESP.
- Sub-module uart_wbm_rx: synchroniser, start/glitch detect, mid-bit sampling, framing check, rx_valid/rx_byte out.
- TX serializer and parser remain in the top module.

Test Plan:
- Write, CLK_DIV=16: send 57 30 00 00 08 00 00 00 05; slave acks after 3 cycles.
  -> One cycle with adr=0x30000008, dat=0x5, we=1, sel=F; ser_tx sends 0x4B; busy returns to 0.
- Read: send 52 30 00 00 04; slave returns 0xDEADBEEF with a 0-wait ack.
  -> we=0; TX bytes DE AD BE EF back-to-back, 160 cycles per byte.
- Garbage and framing: send 0x41, then 0x57 with the stop bit held low, then a valid 'R' frame.
  -> No bus activity until the 'R' frame completes; read executes normally.
- Glitch: 3-cycle low pulse on ser_rx.
  -> No rx_valid, no state change.
- Reset mid-cycle: assert wb_rst_i asynchronously while stb=1 (between clock edges).
  -> cyc/stb drop without a clock edge; ser_tx=1; no response is ever sent.
- With UART_WB_MASTER_TIMEOUT_EN, TIMEOUT=64: read to a non-acking slave.
  -> stb held exactly 64 cycles, then drops; ser_tx sends 0x45 only.

Source files
------------

// File: rtl/uart_wbm_pkg.sv
// Shared constants and state encodings for the UART-to-Wishbone bridge.
package uart_wbm_pkg;

   localparam logic [7:0] CMD_WR  = 8'h57;
   localparam logic [7:0] CMD_RD  = 8'h52;
   localparam logic [7:0] RSP_OK  = 8'h4B;
   localparam logic [7:0] RSP_ERR = 8'h45;

   typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, RESP} parser_state_e;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/uart_wbm_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, glitch-rejecting start detect,
// mid-bit sampling and stop-bit framing check.
module uart_wbm_rx
   import uart_wbm_pkg::*;
#(
   parameter int CLK_DIV = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic       rx_valid,
   output logic [7:0] rx_byte,
   output logic       frame_err
);

   localparam int DW = $clog2(CLK_DIV) + 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2 - 1);

   // sync_q[1] is the synchronised line, sync_q[2] its previous value
   logic [2:0]    sync_q, sync_d;
   rx_state_e     state_q, state_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   logic [7:0]    byte_q, byte_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;

   always_comb begin
      sync_d  = {sync_q[1:0], rx_i};
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      byte_d  = byte_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (sync_q[2] && !sync_q[1]) state_d = RX_START;
         end
         RX_START: begin
            if (cnt_q == DIV_HALF) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = sync_q[1] ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d  = '0;
               byte_d = {sync_q[1], byte_q[7:1]};
               bit_d  = bit_q + 1'b1;
               if (bit_q == 4'd7) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d   = '0;
               state_d = RX_IDLE;
               valid_d = sync_q[1];
               ferr_d  = ~sync_q[1];
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= 3'b111;
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign rx_valid  = valid_q;
   assign rx_byte   = byte_q;
   assign frame_err = ferr_q;

endmodule

// File: rtl/uart_wb_master.sv
// UART command port driving single 32-bit Wishbone initiator cycles.
// Optional bus timeout with 'E' response: define UART_WB_MASTER_TIMEOUT_EN.
module uart_wb_master
   import uart_wbm_pkg::*;
#(
   parameter int CLK_DIV = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        ser_rx,
   output logic        ser_tx,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_we_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   input  logic        wbm_ack_i,
   input  logic [31:0] wbm_dat_i,
   output logic        busy
);

   localparam int DW = $clog2(CLK_DIV) + 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic       rx_valid, frame_err;
   logic [7:0] rx_byte;

   uart_wbm_rx #(.CLK_DIV(CLK_DIV)) u_rx (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .rx_i      (ser_rx),
      .rx_valid  (rx_valid),
      .rx_byte   (rx_byte),
      .frame_err (frame_err)
   );

   parser_state_e state_q, state_d;
   logic          wr_q, wr_d;
   logic [1:0]    bcnt_q, bcnt_d;
   logic [31:0]   adr_q, adr_d, dat_q, dat_d, resp_q, resp_d;
   logic [3:0]    sel_q, sel_d;
   logic          stb_q, stb_d, we_q, we_d;
   logic [2:0]    left_q, left_d;
   logic [9:0]    tx_sh_q, tx_sh_d;
   logic [3:0]    tx_bit_q, tx_bit_d;
   logic [DW-1:0] tx_div_q, tx_div_d;
   logic          tx_act_q, tx_act_d;
   logic          tx_end, tx_ready, tx_load, start_bus, bus_done;

`ifdef UART_WB_MASTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
   logic [TW-1:0] to_cnt_q, to_cnt_d;
`else
   logic timeout_unused;
   assign timeout_unused = (TIMEOUT != 0);
`endif

   // tx_ready also fires on the last stop-bit cycle so response bytes run back-to-back
   assign tx_end   = tx_act_q && (tx_div_q == DIV_LAST) && (tx_bit_q == 4'd9);
   assign tx_ready = !tx_act_q || tx_end;

   always_comb begin
      state_d   = state_q;
      wr_d      = wr_q;
      bcnt_d    = bcnt_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      resp_d    = resp_q;
      sel_d     = sel_q;
      stb_d     = stb_q;
      we_d      = we_q;
      left_d    = left_q;
      tx_load   = 1'b0;
      start_bus = 1'b0;
      bus_done  = 1'b0;
`ifdef UART_WB_MASTER_TIMEOUT_EN
      to_cnt_d  = to_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (rx_valid && (rx_byte == CMD_WR || rx_byte == CMD_RD)) begin
               wr_d    = (rx_byte == CMD_WR);
               bcnt_d  = '0;
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (frame_err) state_d = IDLE;
            else if (rx_valid) begin
               adr_d  = {adr_q[23:0], rx_byte};
               bcnt_d = bcnt_q + 1'b1;
               if (bcnt_q == 2'd3) begin
                  if (wr_q) state_d = WDATA;
                  else      start_bus = 1'b1;
               end
            end
         end
         WDATA: begin
            if (frame_err) state_d = IDLE;
            else if (rx_valid) begin
               dat_d  = {dat_q[23:0], rx_byte};
               bcnt_d = bcnt_q + 1'b1;
               if (bcnt_q == 2'd3) start_bus = 1'b1;
            end
         end
         BUS: begin
            if (wbm_ack_i) begin
               bus_done = 1'b1;
               resp_d   = wr_q ? {RSP_OK, 24'h0} : wbm_dat_i;
               left_d   = wr_q ? 3'd1 : 3'd4;
            end
`ifdef UART_WB_MASTER_TIMEOUT_EN
            else if (to_cnt_q == TO_LAST) begin
               bus_done = 1'b1;
               resp_d   = {RSP_ERR, 24'h0};
               left_d   = 3'd1;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
`endif
         end
         RESP: begin
            if (tx_ready) begin
               if (left_q != 3'd0) begin
                  tx_load = 1'b1;
                  resp_d  = {resp_q[23:0], 8'h00};
                  left_d  = left_q - 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (start_bus) begin
         state_d = BUS;
         stb_d   = 1'b1;
         sel_d   = 4'hF;
         we_d    = wr_q;
`ifdef UART_WB_MASTER_TIMEOUT_EN
         to_cnt_d = '0;
`endif
      end
      if (bus_done) begin
         state_d = RESP;
         stb_d   = 1'b0;
         sel_d   = 4'h0;
         we_d    = 1'b0;
      end
   end

   // tx_sh_q[0] drives the line; idle shifter is all ones
   always_comb begin
      tx_sh_d  = tx_sh_q;
      tx_bit_d = tx_bit_q;
      tx_act_d = tx_act_q;
      tx_div_d = '0;
      if (tx_act_q) begin
         tx_div_d = (tx_div_q == DIV_LAST) ? '0 : tx_div_q + 1'b1;
         if (tx_div_q == DIV_LAST) begin
            tx_sh_d  = {1'b1, tx_sh_q[9:1]};
            tx_bit_d = tx_bit_q + 1'b1;
            if (tx_bit_q == 4'd9) tx_act_d = 1'b0;
         end
      end
      if (tx_load) begin
         tx_sh_d  = {1'b1, resp_q[31:24], 1'b0};
         tx_bit_d = '0;
         tx_div_d = '0;
         tx_act_d = 1'b1;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q  <= IDLE;
         wr_q     <= 1'b0;
         bcnt_q   <= '0;
         adr_q    <= '0;
         dat_q    <= '0;
         resp_q   <= '0;
         sel_q    <= '0;
         stb_q    <= 1'b0;
         we_q     <= 1'b0;
         left_q   <= '0;
         tx_sh_q  <= '1;
         tx_bit_q <= '0;
         tx_div_q <= '0;
         tx_act_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_q     <= wr_d;
         bcnt_q   <= bcnt_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         resp_q   <= resp_d;
         sel_q    <= sel_d;
         stb_q    <= stb_d;
         we_q     <= we_d;
         left_q   <= left_d;
         tx_sh_q  <= tx_sh_d;
         tx_bit_q <= tx_bit_d;
         tx_div_q <= tx_div_d;
         tx_act_q <= tx_act_d;
      end
   end

`ifdef UART_WB_MASTER_TIMEOUT_EN
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) to_cnt_q <= '0;
      else          to_cnt_q <= to_cnt_d;
   end
`endif

   assign ser_tx    = tx_sh_q[0];
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = dat_q;
   assign wbm_sel_o = sel_q;
   assign wbm_we_o  = we_q;
   assign wbm_cyc_o = stb_q;
   assign wbm_stb_o = stb_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_wb_master.sv
// Scoreboard bench: stimulus queues expected bus cycles and TX bytes,
// independent monitors decode the bus and the TX line and compare.
module tb_uart_wb_master;

   localparam int CLK_DIV = 16;
   localparam int TIMEOUT = 64;
   localparam int FRAME   = 10 * CLK_DIV;

   typedef struct {logic [31:0] adr; logic [31:0] dat; logic we; int len;} bus_exp_t;
   typedef struct {logic [7:0] b; bit first;} tx_exp_t;

   logic        clk = 1'b0, rst = 1'b1, ser_rx = 1'b1;
   logic        ser_tx, we, cyc, stb, ack, busy;
   logic [31:0] adr, dat_o, dat_i;
   logic [3:0]  sel;

   int n_chk = 0, n_fail = 0, cyc_n = 0, last_end = 0, wait_cnt = 0, ack_dly = 0;
   bit ack_en = 1'b1;
   logic [31:0] rdata = '0;
   bus_exp_t bus_q[$];
   tx_exp_t  tx_q[$];

   uart_wb_master #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .ser_rx(ser_rx), .ser_tx(ser_tx),
      .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_sel_o(sel), .wbm_we_o(we),
      .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_ack_i(ack), .wbm_dat_i(dat_i),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;
   always @(posedge clk) wait_cnt <= (stb && !ack) ? wait_cnt + 1 : 0;

   // slave model: acks after ack_dly wait cycles, drives junk when not acking
   always_comb begin
      ack   = stb && ack_en && (wait_cnt == ack_dly);
      dat_i = ack ? rdata : ~rdata;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin : bus_mon
      bus_exp_t e;
      int  len;
      bit  act;
      act = 1'b0; len = 0; e.len = -1;
      forever begin
         @(negedge clk);
         if (stb && !act) begin
            act = 1'b1; len = 0;
            if (bus_q.size() == 0) begin
               n_chk++; n_fail++; e.len = -1;
               $display("FAIL bus_unexpected: adr %h we %b", adr, we);
            end else begin
               e = bus_q.pop_front();
               check("bus_adr", adr, e.adr);
               check("bus_we", 32'(we), 32'(e.we));
               check("bus_sel", 32'(sel), 32'hF);
               check("bus_cyc", 32'(cyc), 32'h1);
               if (e.we) check("bus_dat", dat_o, e.dat);
            end
         end
         if (stb) len++;
         else if (act) begin
            act = 1'b0;
            last_end = cyc_n;
            if (e.len >= 0) check("bus_len", 32'(len), 32'(e.len));
         end
      end
   end

   initial begin : tx_mon
      tx_exp_t e;
      logic [7:0] b;
      int start, prev_start;
      prev_start = 0;
      forever begin
         @(negedge clk);
         if (!rst && ser_tx === 1'b0) begin
            start = cyc_n;
            repeat (CLK_DIV / 2) @(negedge clk);
            check("tx_start_bit", 32'(ser_tx), 32'h0);
            for (int i = 0; i < 8; i++) begin
               repeat (CLK_DIV) @(negedge clk);
               b[i] = ser_tx;
            end
            repeat (CLK_DIV) @(negedge clk);
            check("tx_stop_bit", 32'(ser_tx), 32'h1);
            if (tx_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL tx_unexpected: byte %h", b);
            end else begin
               e = tx_q.pop_front();
               check("tx_byte", 32'(b), 32'(e.b));
               check("tx_start_cycle", 32'(start), e.first ? 32'(last_end + 1) : 32'(prev_start + FRAME));
            end
            prev_start = start;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      @(negedge clk);
      ser_rx = 1'b0;
      repeat (CLK_DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         ser_rx = b[i];
         repeat (CLK_DIV) @(negedge clk);
      end
      ser_rx = stop_ok;
      repeat (CLK_DIV) @(negedge clk);
      ser_rx = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      repeat (4) @(negedge clk);
      while (busy && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(busy), 32'h0);
   endtask

   initial begin : stim
      int n;
      repeat (3) @(negedge clk);
      check("rst_ser_tx", 32'(ser_tx), 32'h1);
      check("rst_cyc", 32'(cyc), 32'h0);
      check("rst_stb", 32'(stb), 32'h0);
      check("rst_we", 32'(we), 32'h0);
      check("rst_adr", adr, 32'h0);
      check("rst_dat", dat_o, 32'h0);
      check("rst_sel", 32'(sel), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // write, slave acks after 3 wait cycles
      ack_en = 1'b1; ack_dly = 3;
      bus_q.push_back('{32'h3000_0008, 32'h0000_0005, 1'b1, 4});
      tx_q.push_back('{8'h4B, 1'b1});
      send_byte(8'h57, 1'b1); send_word(32'h3000_0008); send_word(32'h0000_0005);
      wait_idle("write_busy_clear");

      // read, zero-wait ack
      ack_dly = 0; rdata = 32'hDEAD_BEEF;
      bus_q.push_back('{32'h3000_0004, 32'h0, 1'b0, 1});
      tx_q.push_back('{8'hDE, 1'b1}); tx_q.push_back('{8'hAD, 1'b0});
      tx_q.push_back('{8'hBE, 1'b0}); tx_q.push_back('{8'hEF, 1'b0});
      send_byte(8'h52, 1'b1); send_word(32'h3000_0004);
      wait_idle("read_busy_clear");

      // garbage byte, then a 'W' with a low stop bit, then a good read
      send_byte(8'h41, 1'b1);
      check("garbage_idle", 32'(busy), 32'h0);
      send_byte(8'h57, 1'b0);
      repeat (4) @(negedge clk);
      check("framing_idle", 32'(busy), 32'h0);
      ack_dly = 1; rdata = 32'h0123_4567;
      bus_q.push_back('{32'h1020_3040, 32'h0, 1'b0, 2});
      tx_q.push_back('{8'h01, 1'b1}); tx_q.push_back('{8'h23, 1'b0});
      tx_q.push_back('{8'h45, 1'b0}); tx_q.push_back('{8'h67, 1'b0});
      send_byte(8'h52, 1'b1); send_word(32'h1020_3040);
      wait_idle("frame_read_busy_clear");

      // 3-cycle glitch on the line
      ser_rx = 1'b0;
      repeat (3) @(negedge clk);
      ser_rx = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch_idle", 32'(busy), 32'h0);

`ifdef UART_WB_MASTER_TIMEOUT_EN
      // read to a slave that never acks
      ack_en = 1'b0;
      bus_q.push_back('{32'h0000_00C0, 32'h0, 1'b0, TIMEOUT});
      tx_q.push_back('{8'h45, 1'b1});
      send_byte(8'h52, 1'b1); send_word(32'h0000_00C0);
      wait_idle("timeout_busy_clear");
`endif

      // async reset while a write is stalled on the bus
      ack_en = 1'b0;
      bus_q.push_back('{32'h0000_0100, 32'hA5A5_A5A5, 1'b1, -1});
      send_byte(8'h57, 1'b1); send_word(32'h0000_0100); send_word(32'hA5A5_A5A5);
      n = 0;
      while (!stb && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("rst_test_stb_seen", 32'(stb), 32'h1);
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("async_rst_cyc", 32'(cyc), 32'h0);
      check("async_rst_stb", 32'(stb), 32'h0);
      check("async_rst_ser_tx", 32'(ser_tx), 32'h1);
      check("async_rst_busy", 32'(busy), 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0; ack_en = 1'b1;
      repeat (400) @(negedge clk);
      check("post_rst_idle", 32'(busy), 32'h0);

      check("bus_queue_drained", 32'(bus_q.size()), 32'h0);
      check("tx_queue_drained", 32'(tx_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
